// File: rtl/dir_sequence_lock.sv
// Directional combination lock: the user enters SEQ_LEN codes, with retry handling, lockout and a programmable sequence.
// Optional macro DIR_LOCK_TIMEOUT_EN adds an inter-entry timeout that counts as a wrong code.
module dir_sequence_lock #(
   parameter  int DIR_W       = 3,
   parameter  int SEQ_LEN     = 5,
   parameter  int MAX_TRIES   = 3,
   parameter  int LOCKOUT_CYC = 1000,
   parameter  int TIMEOUT_CYC = 500,
   localparam int IDX_W       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
   localparam int PROG_W      = $clog2(SEQ_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dir_valid,
   input  logic [DIR_W-1:0]  dir_in,
   input  logic              retry,
   input  logic              prog_en,
   input  logic [IDX_W-1:0]  prog_idx,
   input  logic [DIR_W-1:0]  prog_data,
   output logic              done,
   output logic              fail,
   output logic              alarm,
   output logic [PROG_W-1:0] progress,
   output logic [3:0]        tries_left,
   output logic [1:0]        fsm_state
);

   localparam int LCNT_W = $clog2(LOCKOUT_CYC + 1);

   localparam logic [PROG_W-1:0] LAST_POS  = PROG_W'(SEQ_LEN - 1);
   localparam logic [PROG_W-1:0] FULL_POS  = PROG_W'(SEQ_LEN);
   localparam logic [IDX_W:0]    SEQ_LIM   = (IDX_W + 1)'(SEQ_LEN);
   localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);
   localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(LOCKOUT_CYC);
   localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_DONE    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [PROG_W-1:0]   prog_n;
   logic [3:0]          tries_n;
   logic [3:0]          tries_dec;
   logic [LCNT_W-1:0]   lcnt, lcnt_n;
   logic [DIR_W-1:0]    seq [0:SEQ_LEN-1];
   logic [DIR_W-1:0]    cur_code;
   logic                wr_en;
   logic                timeout_hit;
   logic                mismatch;

   assign fsm_state = state;
   assign cur_code  = seq[progress[IDX_W-1:0]];
   assign tries_dec = tries_left - 4'd1;
   assign wr_en     = (state == ST_DONE) && prog_en && ({1'b0, prog_idx} < SEQ_LIM);

`ifdef DIR_LOCK_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Only idle cycles in the middle of an entry age the timer; an accepted code restarts it.
   assign timeout_hit = (state == ST_ENTRY) && (progress != '0) && !dir_valid
                        && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if ((state == ST_ENTRY) && (progress != '0) && !dir_valid && !timeout_hit) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      prog_n   = progress;
      tries_n  = tries_left;
      lcnt_n   = lcnt;
      mismatch = 1'b0;
      case (state)
         ST_ENTRY: begin
            if (dir_valid) begin
               if (dir_in == cur_code) begin
                  if (progress == LAST_POS) begin
                     state_n = ST_DONE;
                     prog_n  = FULL_POS;
                  end else begin
                     prog_n = progress + PROG_W'(1);
                  end
               end else begin
                  mismatch = 1'b1;
               end
            end else if (timeout_hit) begin
               mismatch = 1'b1;
            end
            if (mismatch) begin
               tries_n = tries_dec;
               prog_n  = '0;
               if (tries_dec == 4'd0) begin
                  state_n = ST_LOCKOUT;
                  lcnt_n  = LCNT_LOAD;
               end else begin
                  state_n = ST_FAIL;
               end
            end
         end
         ST_FAIL: begin
            if (retry) begin
               state_n = ST_ENTRY;
               prog_n  = '0;
            end
         end
         ST_LOCKOUT: begin
            // The load value counts the first lockout cycle, so leave when the count reaches one.
            if (lcnt <= LCNT_ONE) begin
               state_n = ST_ENTRY;
               tries_n = TRIES_MAX;
               lcnt_n  = '0;
            end else begin
               lcnt_n = lcnt - LCNT_ONE;
            end
         end
         ST_DONE: begin
            if (retry) begin
               state_n = ST_ENTRY;
               prog_n  = '0;
               tries_n = TRIES_MAX;
            end
         end
         default: begin
            state_n = ST_ENTRY;
            prog_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_ENTRY;
         progress   <= '0;
         tries_left <= TRIES_MAX;
         lcnt       <= '0;
         done       <= 1'b0;
         fail       <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state      <= state_n;
         progress   <= prog_n;
         tries_left <= tries_n;
         lcnt       <= lcnt_n;
         done       <= (state_n == ST_DONE);
         fail       <= (state_n == ST_FAIL);
         alarm      <= (state_n == ST_LOCKOUT);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SEQ_LEN; i++) begin
            seq[i] <= DIR_W'(i);
         end
      end else if (wr_en) begin
         seq[prog_idx] <= prog_data;
      end
   end

endmodule

// File: tb/tb_dir_sequence_lock.sv
// Directed scoreboard bench for dir_sequence_lock: the driver queues hand-computed expected outputs,
// and the monitor compares them one clock edge after each driven cycle.
module tb_dir_sequence_lock;

   localparam int W = 10;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       dir_valid = 1'b0;
   logic [2:0] dir_in    = '0;
   logic       retry     = 1'b0;
   logic       prog_en   = 1'b0;
   logic [2:0] prog_idx  = '0;
   logic [2:0] prog_data = '0;
   logic       done, fail, alarm;
   logic [2:0] progress;
   logic [3:0] tries_left;
   logic [1:0] fsm_state;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           passed = 0;
   logic [W-1:0] got_v, exp_v;
   string        cur_name;

   always #5 clk = ~clk;

   dir_sequence_lock dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dir_valid  (dir_valid),
      .dir_in     (dir_in),
      .retry      (retry),
      .prog_en    (prog_en),
      .prog_idx   (prog_idx),
      .prog_data  (prog_data),
      .done       (done),
      .fail       (fail),
      .alarm      (alarm),
      .progress   (progress),
      .tries_left (tries_left),
      .fsm_state  (fsm_state)
   );

   function automatic logic [W-1:0] ex(input logic d, input logic f, input logic a,
                                       input int p, input int t);
      return {d, f, a, 3'(p), 4'(t)};
   endfunction

   task automatic cyc(input logic rn, input logic v, input logic [2:0] d, input logic r,
                      input logic pe, input logic [2:0] pi, input logic [2:0] pd,
                      input logic [W-1:0] e, input string nm);
      @(negedge clk);
      reset_n   = rn;
      dir_valid = v;
      dir_in    = d;
      retry     = r;
      prog_en   = pe;
      prog_idx  = pi;
      prog_data = pd;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic code(input logic [2:0] d, input logic [W-1:0] e, input string nm);
      cyc(1'b1, 1'b1, d, 1'b0, 1'b0, 3'd0, 3'd0, e, nm);
   endtask

   task automatic idle(input logic [W-1:0] e, input string nm);
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, e, nm);
   endtask

   task automatic rty(input logic [W-1:0] e, input string nm);
      cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, e, nm);
   endtask

   task automatic rst_pulse(input string nm);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, ex(0, 0, 0, 0, 3), nm);
   endtask

   // Monitor: every posted expectation is checked after the next rising edge.
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_v    = exp_q.pop_front();
         cur_name = name_q.pop_front();
         got_v    = {done, fail, alarm, progress, tries_left};
         checks++;
         if (got_v === exp_v) begin
            passed++;
         end else begin
            $display("FAIL %s: got done=%0b fail=%0b alarm=%0b progress=%0d tries_left=%0d, expected done=%0b fail=%0b alarm=%0b progress=%0d tries_left=%0d",
                     cur_name, got_v[9], got_v[8], got_v[7], got_v[6:4], got_v[3:0],
                     exp_v[9], exp_v[8], exp_v[7], exp_v[6:4], exp_v[3:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      // Reset and a clean unlock with the default sequence.
      rst_pulse("reset_state");
      rst_pulse("reset_hold");
      idle(ex(0, 0, 0, 0, 3), "reset_release");
      for (int i = 0; i < 4; i++) code(3'(i), ex(0, 0, 0, i + 1, 3), "progress_step");
      code(3'd4, ex(1, 0, 0, 5, 3), "done_after_5th");
      code(3'd3, ex(1, 0, 0, 5, 3), "done_ignores_dir");
      rty(ex(0, 0, 0, 0, 3), "relock_from_done");

      // Retry is ignored in ENTRY; idle holds progress.
      rty(ex(0, 0, 0, 0, 3), "retry_ignored_entry");
      code(3'd0, ex(0, 0, 0, 1, 3), "first_code");
      rty(ex(0, 0, 0, 1, 3), "retry_ignored_mid");
      idle(ex(0, 0, 0, 1, 3), "idle_hold");

      // Wrong code, FAIL handling, then a successful retry.
      code(3'd1, ex(0, 0, 0, 2, 3), "second_code");
      code(3'd7, ex(0, 1, 0, 0, 2), "wrong_code_fail");
      code(3'd0, ex(0, 1, 0, 0, 2), "fail_ignores_dir");
      rty(ex(0, 0, 0, 0, 2), "retry_from_fail");
      for (int i = 0; i < 4; i++) code(3'(i), ex(0, 0, 0, i + 1, 2), "retry_progress");
      code(3'd4, ex(1, 0, 0, 5, 2), "done_after_retry");
      rty(ex(0, 0, 0, 0, 3), "relock_restores_tries");

      // Three wrong sequences lead to a lockout of exactly 1000 cycles.
      code(3'd5, ex(0, 1, 0, 0, 2), "wrong_1");
      rty(ex(0, 0, 0, 0, 2), "retry_1");
      code(3'd0, ex(0, 0, 0, 1, 2), "partial_2");
      code(3'd0, ex(0, 1, 0, 0, 1), "wrong_2");
      rty(ex(0, 0, 0, 0, 1), "retry_2");
      code(3'd6, ex(0, 0, 1, 0, 0), "lockout_entry");
      for (int i = 0; i < 999; i++) begin
         if (i % 2 == 1) rty(ex(0, 0, 1, 0, 0), "lockout_hold_retry");
         else code(3'(i % 8), ex(0, 0, 1, 0, 0), "lockout_hold_dir");
      end
      idle(ex(0, 0, 0, 0, 3), "lockout_exit");
      code(3'd0, ex(0, 0, 0, 1, 3), "entry_after_lockout");

      // Reset in the middle of a second lockout.
      code(3'd7, ex(0, 1, 0, 0, 2), "wrong_a");
      rty(ex(0, 0, 0, 0, 2), "retry_a");
      code(3'd7, ex(0, 1, 0, 0, 1), "wrong_b");
      rty(ex(0, 0, 0, 0, 1), "retry_b");
      code(3'd7, ex(0, 0, 1, 0, 0), "lockout_again");
      for (int i = 0; i < 5; i++) idle(ex(0, 0, 1, 0, 0), "lockout_again_hold");
      rst_pulse("reset_mid_lockout");
      for (int i = 0; i < 3; i++) idle(ex(0, 0, 0, 0, 3), "no_alarm_after_reset");

      // Programming: ignored outside DONE, out-of-range index ignored, write with relock.
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd5, ex(0, 0, 0, 0, 3), "prog_ignored_entry");
      for (int i = 0; i < 4; i++) code(3'(i), ex(0, 0, 0, i + 1, 3), "prog_setup");
      code(3'd4, ex(1, 0, 0, 5, 3), "prog_setup_done");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd0, ex(1, 0, 0, 5, 3), "prog_idx_out_of_range");
      cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 3'd6, ex(0, 0, 0, 0, 3), "prog_with_retry_relocks");
      code(3'd0, ex(0, 0, 0, 1, 3), "new_seq_0");
      code(3'd1, ex(0, 0, 0, 2, 3), "new_seq_1");
      code(3'd6, ex(0, 0, 0, 3, 3), "new_seq_6");
      code(3'd3, ex(0, 0, 0, 4, 3), "new_seq_3");
      code(3'd4, ex(1, 0, 0, 5, 3), "new_seq_done");
      rty(ex(0, 0, 0, 0, 3), "relock_new_seq");
      code(3'd0, ex(0, 0, 0, 1, 3), "old_seq_0");
      code(3'd1, ex(0, 0, 0, 2, 3), "old_seq_1");
      code(3'd2, ex(0, 1, 0, 0, 2), "old_code_rejected");
      rty(ex(0, 0, 0, 0, 2), "retry_old_seq");

      // Reset restores the default sequence and tries.
      rst_pulse("reset_after_prog");
      idle(ex(0, 0, 0, 0, 3), "reset_after_prog_release");
      for (int i = 0; i < 4; i++) code(3'(i), ex(0, 0, 0, i + 1, 3), "default_seq_step");
      code(3'd4, ex(1, 0, 0, 5, 3), "default_seq_after_reset");
      rty(ex(0, 0, 0, 0, 3), "relock_final");

`ifdef DIR_LOCK_TIMEOUT_EN
      code(3'd0, ex(0, 0, 0, 1, 3), "timeout_start");
      for (int i = 0; i < 499; i++) idle(ex(0, 0, 0, 1, 3), "timeout_wait");
      idle(ex(0, 1, 0, 0, 2), "timeout_fail");
      rty(ex(0, 0, 0, 0, 2), "timeout_retry");
      for (int i = 0; i < 520; i++) idle(ex(0, 0, 0, 0, 2), "no_timeout_at_zero");
`else
      code(3'd0, ex(0, 0, 0, 1, 3), "wait_start");
      for (int i = 0; i < 600; i++) idle(ex(0, 0, 0, 1, 3), "entry_waits");
`endif

      repeat (3) @(posedge clk);
      #4;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
